// File: rtl/fpmu_seq.sv
// -----------------------------------------------------------------------------
// fpmu_seq - operand-load / result-return sequencer for the multi-cycle
// half-precision FP multiplier.
//
// Collects four operand bytes over an 8-bit valid/ready stream
// (mul_a[7:0], mul_a[15:8], mul_b[7:0], mul_b[15:8]), issues a one-cycle
// mul_start, waits for mul_done, then streams result[7:0], result[15:8] and
// a flags byte {err, 3'b000, flags} back out. Keeps a 0..9 count of
// completed operations for the seg7 display.
//
// Optional feature macro: FPMU_SEQ_TIMEOUT_EN
//   defined   : 24-bit WAIT watchdog; on expiry the result is forced to qNaN
//               (16'h7E00), flags to 4'b1000 and err is set.
//   undefined : WAIT leaves only on mul_done; err is constant 0 and
//               TIMEOUT_CYCLES is ignored.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_data/in_valid    operand byte stream in, in_ready back-pressure out
//   mul_a, mul_b        registered operands to the multiplier
//   mul_start           one-cycle start pulse
//   mul_done            result strobe (only honoured in WAIT)
//   mul_result          16-bit product, valid with mul_done
//   mul_flags           {NaN, overflow, underflow, inexact}, valid with done
//   out_data/out_valid  result byte stream out, out_ready back-pressure in
//   busy                high whenever not IDLE
//   state               debug state encoding (IDLE=0 .. SEND=4)
//   err                 timeout flag for the current operation
//   op_digit            completed operations mod 10
// -----------------------------------------------------------------------------
module fpmu_seq #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [15:0] mul_result,
  input  logic [3:0]  mul_flags,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [2:0]  state,
  output logic        err,
  output logic [3:0]  op_digit
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SEND  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d;
  logic        err_q, err_d;
  logic [3:0]  digit_q, digit_d;
  logic        in_ready_q, in_ready_d;
  logic        start_q, start_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        busy_q, busy_d;
  logic        in_hs_s;
  logic        out_hs_s;

`ifdef FPMU_SEQ_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
`else
  logic [23:0] unused_timeout_s;
  assign unused_timeout_s = TIMEOUT_CYCLES;
`endif

  // Selects the output byte for a given SEND position.
  function automatic logic [7:0] send_byte(input logic [1:0]  idx,
                                           input logic [15:0] res,
                                           input logic [3:0]  flags,
                                           input logic        e);
    logic [7:0] b;
    case (idx)
      2'd0:    b = res[7:0];
      2'd1:    b = res[15:8];
      default: b = {e, 3'b000, flags};
    endcase
    return b;
  endfunction

  assign in_hs_s  = in_valid && in_ready_q;
  assign out_hs_s = out_valid_q && out_ready;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
    digit_d = digit_q;
`ifdef FPMU_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_hs_s) begin
          a_d[7:0] = in_data;
          err_d    = 1'b0;
          idx_d    = 2'd1;
          state_d  = ST_LOAD;
        end else begin
          idx_d = 2'd0;
        end
      end
      ST_LOAD: begin
        if (in_hs_s) begin
          case (idx_q)
            2'd0:    a_d[7:0]  = in_data;
            2'd1:    a_d[15:8] = in_data;
            2'd2:    b_d[7:0]  = in_data;
            default: b_d[15:8] = in_data;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_ISSUE: begin
        idx_d   = 2'd0;
        state_d = ST_WAIT;
`ifdef FPMU_SEQ_TIMEOUT_EN
        cnt_d   = 24'd0;
`endif
      end
      ST_WAIT: begin
        // A done arriving in the expiry cycle takes priority over the abort.
        if (mul_done) begin
          res_d   = mul_result;
          flags_d = mul_flags;
          idx_d   = 2'd0;
          state_d = ST_SEND;
`ifdef FPMU_SEQ_TIMEOUT_EN
        end else if (cnt_q == (TIMEOUT_CYCLES - 24'd1)) begin
          res_d   = 16'h7E00;
          flags_d = 4'b1000;
          err_d   = 1'b1;
          idx_d   = 2'd0;
          state_d = ST_SEND;
        end else begin
          cnt_d   = cnt_q + 24'd1;
        end
`else
        end else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_SEND: begin
        if (out_hs_s) begin
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = ST_IDLE;
            digit_d = (digit_q == 4'd9) ? 4'd0 : (digit_q + 4'd1);
          end else begin
            idx_d   = idx_q + 2'd1;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from next state so they leave the block registered.
    in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    start_d     = (state_d == ST_ISSUE);
    out_valid_d = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE);
    if (state_d == ST_SEND) begin
      out_data_d = send_byte(idx_d, res_d, flags_d, err_d);
    end else begin
      out_data_d = 8'h00;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      res_q       <= 16'h0000;
      flags_q     <= 4'd0;
      err_q       <= 1'b0;
      digit_q     <= 4'd0;
      in_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      busy_q      <= 1'b0;
`ifdef FPMU_SEQ_TIMEOUT_EN
      cnt_q       <= 24'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      digit_q     <= digit_d;
      in_ready_q  <= in_ready_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
`ifdef FPMU_SEQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign mul_start = start_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state     = state_q;
  assign err       = err_q;
  assign op_digit  = digit_q;

endmodule
